gpio_peer: RTL and testbench
============================

Name: gpio_peer

Overview:
- Board-side counterpart of the CPU GPIO interface.
- Input path: synchronises and debounces raw switch inputs, then drives the CPU's gpio_in word.
- Output path: watches the CPU's gpio_out word for changes and queues each new value in a small FIFO.
- The FIFO drains through a valid/ready event port to display or serial logic.
- Sits between the cpu top level and the board I/O.

Parameters:
- DEB_CYCLES, 4, consecutive stable cycles required before a new switch word is accepted (>=1).
- FIFO_DEPTH, 4, output-event FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset; asserted when rst==0.
- sw_in  input  32  raw asynchronous board switches/buttons.
- gpio_in  output  32  debounced word to CPU gpio_in.
- gpio_out  input  32  CPU gpio_out word, synchronous to clk.
- evt_data  output  32  FIFO head value.
- evt_valid  output  1  FIFO non-empty.
- evt_ready  input  1  consumer accepts head this cycle.
- evt_overflow  output  1  sticky: an event was dropped.
- ovf_clr  input  1  clears evt_overflow.

Behaviour:
Reset (rst==0, asynchronous):
- gpio_in=0, evt_valid=0, evt_data=0, evt_overflow=0.
- Synchroniser flops, candidate word, debounce count, last_out, FIFO pointers and count all =0.
- Registers hold their reset values while rst is low.
- Operation resumes on the first clk edge after rst rises.
- A reset mid-debounce or mid-drain discards all state; no partial event is emitted.

Input path:
- 2-flop synchroniser per bit (sync1 -> sync2).
- If sync2 != candidate: candidate<=sync2, count<=0.
- Else, if count==DEB_CYCLES-1: gpio_in<=candidate, and count holds.
- Else: count<=count+1.
- Latency: a sw_in change held stable from cycle 0 appears on gpio_in after the edge 3+DEB_CYCLES (DEB_CYCLES=4 -> visible in cycle 7).
- A glitch shorter than DEB_CYCLES+1 sync2 cycles never reaches gpio_in.
- gpio_in changes only as a whole word, never bitwise-partial.

Output path:
- Each cycle, if gpio_out != last_out: last_out<=gpio_out and push gpio_out.
- Push occurs in the same cycle the change is seen; gpio_out is not synchronised.
- No push when gpio_out is unchanged; repeated writes of the same value produce no event.
- The FIFO is first-word-fall-through:
  - evt_data = head entry whenever evt_valid=1.
  - evt_data = 0 when empty.
  - Pop when evt_valid && evt_ready.
  - evt_data and evt_valid are held stable while evt_valid && !evt_ready.
- Pushed entry is visible on evt_valid/evt_data the cycle after the push edge.
- Full, push with no pop: entry dropped, evt_overflow<=1, last_out still updates.
- Full, push and pop together: both happen, no overflow.
- Empty: pop is ignored; a push in the same cycle is accepted normally.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH (width clog2(FIFO_DEPTH)+1).
- ovf_clr=1 clears evt_overflow next edge. A drop in the same cycle wins: evt_overflow stays 1.

Optional Feature:
- Macro: GPIO_PEER_TIMESTAMP_EN.
- Defined:
  - Adds output evt_time[15:0].
  - A free-running 16-bit cycle counter resets to 0, increments every clk, and wraps 0xFFFF->0x0000.
  - The counter value at the push edge is stored alongside each entry.
  - evt_time follows evt_data with identical hold rules; it is 0 when empty.
- Undefined: port, counter and timestamp storage are absent; behaviour is otherwise identical.

Test Plan:
- Reset: drive rst=0 with sw_in=0xFFFFFFFF, gpio_out=0x5 -> all outputs 0 during reset. After release: gpio_in=0xFFFFFFFF visible in cycle 7, and one event 0x5 is queued.
- Glitch rejection (DEB_CYCLES=4): sw_in 0->0x1 for 3 cycles, then back to 0 -> gpio_in stays 0.
- Stable input (DEB_CYCLES=4): sw_in=0xA5A5A5A5 held -> gpio_in=0xA5A5A5A5 from cycle 7, unchanged before that.
- Change detection: with evt_ready=0, gpio_out sequence 1,1,2,2,3 -> FIFO holds 1,2,3. Then raise evt_ready -> evt_data 1,2,3 on consecutive cycles, then evt_valid=0.
- Overflow (FIFO_DEPTH=4): with evt_ready=0, gpio_out 1..5 -> evt_overflow=1 and drain yields 1,2,3,4. Assert ovf_clr -> evt_overflow=0 next cycle.
- Full with simultaneous push/pop: FIFO full with 1..4, evt_ready=1 and gpio_out=9 in the same cycle -> no overflow, drain yields 2,3,4,9. Backpressure: hold evt_ready=0 for 5 cycles -> evt_data stays stable throughout.

Source files
------------

// File: rtl/gpio_peer.sv
// rtl/gpio_peer.sv - board-side GPIO peer: switch debounce and gpio_out change-event FIFO
// Optional timestamp port evt_time enabled by defining GPIO_PEER_TIMESTAMP_EN.
module gpio_peer #(
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sw_in,
  output logic [31:0] gpio_in,
  input  logic [31:0] gpio_out,
  output logic [31:0] evt_data,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic        evt_overflow,
`ifdef GPIO_PEER_TIMESTAMP_EN
  output logic [15:0] evt_time,
`endif
  input  logic        ovf_clr
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;

  logic [31:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [31:0]   cand_q, cand_d, gpio_in_q, gpio_in_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   last_out_q, last_out_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          change, pop, full, push_ok;
`ifdef GPIO_PEER_TIMESTAMP_EN
  logic [15:0]   ts_q, ts_d;
  logic [15:0]   ts_mem_q [FIFO_DEPTH];
  logic [15:0]   ts_mem_d [FIFO_DEPTH];
`endif

  // Debounce: a new word must stay equal to the candidate for DEB_CYCLES compares.
  always_comb begin
    sync1_d   = sw_in;
    sync2_d   = sync1_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    gpio_in_d = gpio_in_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      gpio_in_d = cand_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    change     = (gpio_out != last_out_q);
    full       = (count_q == NW'(FIFO_DEPTH));
    pop        = (count_q != '0) && evt_ready;
    push_ok    = change && (!full || pop);
    last_out_d = change ? gpio_out : last_out_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
`ifdef GPIO_PEER_TIMESTAMP_EN
    ts_d       = ts_q + 16'd1;
    ts_mem_d   = ts_mem_q;
`endif
    if (push_ok) begin
      mem_d[wr_ptr_q] = gpio_out;
`ifdef GPIO_PEER_TIMESTAMP_EN
      ts_mem_d[wr_ptr_q] = ts_q;
`endif
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop) count_d = count_q + NW'(1);
    else if (!push_ok && pop) count_d = count_q - NW'(1);
    // A drop in the same cycle as ovf_clr keeps the flag set.
    if (change && full && !pop) ovf_d = 1'b1;
    else if (ovf_clr)           ovf_d = 1'b0;
    else                        ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      gpio_in_q  <= '0;
      last_out_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef GPIO_PEER_TIMESTAMP_EN
      ts_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) ts_mem_q[i] <= '0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      gpio_in_q  <= gpio_in_d;
      last_out_q <= last_out_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      mem_q      <= mem_d;
`ifdef GPIO_PEER_TIMESTAMP_EN
      ts_q       <= ts_d;
      ts_mem_q   <= ts_mem_d;
`endif
    end
  end

  always_comb begin
    gpio_in      = gpio_in_q;
    evt_valid    = (count_q != '0);
    evt_data     = evt_valid ? mem_q[rd_ptr_q] : 32'd0;
    evt_overflow = ovf_q;
`ifdef GPIO_PEER_TIMESTAMP_EN
    evt_time     = evt_valid ? ts_mem_q[rd_ptr_q] : 16'd0;
`endif
  end

endmodule

// File: tb/tb_gpio_peer.sv
// tb/tb_gpio_peer.sv - directed and randomized checks of gpio_peer against a queue-based model
module tb_gpio_peer;
  localparam int DEB = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] sw_in = '0;
  logic [31:0] gpio_out = '0;
  logic        evt_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [31:0] gpio_in, evt_data;
  logic        evt_valid, evt_overflow;
`ifdef GPIO_PEER_TIMESTAMP_EN
  logic [15:0] evt_time;
`endif

  int checks = 0;
  int failures = 0;

  gpio_peer #(.DEB_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_overflow(evt_overflow),
`ifdef GPIO_PEER_TIMESTAMP_EN
    .evt_time(evt_time),
`endif
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Model: switch word is accepted once its synchronised value has been seen DEB+1 samples in a row.
  logic [31:0] m_s1, m_s2, m_runval, m_gpio, m_last;
  int          m_run;
  logic        m_ovf;
  logic [15:0] m_time;
  logic [31:0] mq[$];
  logic [15:0] mt[$];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_runval = '0; m_run = 1; m_gpio = '0; m_last = '0;
    m_ovf = 1'b0; m_time = '0; mq.delete(); mt.delete();
  endtask

  task automatic model_edge();
    bit drop;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_s2 == m_runval) begin
      if (m_run <= DEB) m_run++;
    end else begin
      m_runval = m_s2;
      m_run = 1;
    end
    if (m_run >= DEB + 1) m_gpio = m_runval;
    m_s2 = m_s1;
    m_s1 = sw_in;
    if (mq.size() > 0 && evt_ready) begin
      void'(mq.pop_front());
      void'(mt.pop_front());
    end
    drop = 1'b0;
    if (gpio_out != m_last) begin
      m_last = gpio_out;
      if (mq.size() < DEPTH) begin
        mq.push_back(gpio_out);
        mt.push_back(m_time);
      end else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    m_time = m_time + 16'd1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("gpio_in", gpio_in, m_gpio);
    check("evt_valid", 32'(evt_valid), 32'(mq.size() > 0));
    check("evt_data", evt_data, (mq.size() > 0) ? mq[0] : 32'd0);
    check("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
`ifdef GPIO_PEER_TIMESTAMP_EN
    check("evt_time", 32'(evt_time), (mt.size() > 0) ? 32'(mt[0]) : 32'd0);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    logic [31:0] held;
    model_reset();
    // Reset with active inputs: everything reads zero.
    sw_in = 32'hFFFF_FFFF; gpio_out = 32'h5;
    #1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_gpio_in", gpio_in, 32'd0);
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_data", evt_data, 32'd0);
      check("rst_ovf", 32'(evt_overflow), 32'd0);
    end
    rst = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      check("rst_latency", gpio_in, (i == 7) ? 32'hFFFF_FFFF : 32'd0);
    end
    check("rst_event", evt_data, 32'h5);
    evt_ready = 1'b1;
    cyc();
    check("rst_event_gone", 32'(evt_valid), 32'd0);

    // Glitch rejection.
    sw_in = '0;
    for (int i = 0; i < 10; i++) cyc();
    check("settle_zero", gpio_in, 32'd0);
    sw_in = 32'h1;
    for (int i = 0; i < 3; i++) cyc();
    sw_in = '0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("glitch", gpio_in, 32'd0);
    end

    // Stable input latency.
    sw_in = 32'hA5A5_A5A5;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check("stable", gpio_in, (i >= 7) ? 32'hA5A5_A5A5 : 32'd0);
    end

    // Change detection with repeats.
    evt_ready = 1'b0;
    gpio_out = 32'd1; cyc();
    gpio_out = 32'd1; cyc();
    gpio_out = 32'd2; cyc();
    gpio_out = 32'd2; cyc();
    gpio_out = 32'd3; cyc();
    evt_ready = 1'b1;
    check("chg_d0", evt_data, 32'd1); cyc();
    check("chg_d1", evt_data, 32'd2); cyc();
    check("chg_d2", evt_data, 32'd3); cyc();
    check("chg_empty", 32'(evt_valid), 32'd0);

    // Overflow and sticky clear.
    evt_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      gpio_out = 32'(v);
      cyc();
    end
    check("ovf_set", 32'(evt_overflow), 32'd1);
    evt_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      check("ovf_drain", evt_data, 32'(v));
      cyc();
    end
    check("ovf_drained", 32'(evt_valid), 32'd0);
    check("ovf_sticky", 32'(evt_overflow), 32'd1);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    check("ovf_clr", 32'(evt_overflow), 32'd0);

    // Full FIFO with simultaneous push and pop, then backpressure hold.
    evt_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      gpio_out = 32'(v);
      cyc();
    end
    evt_ready = 1'b1; gpio_out = 32'd9; cyc();
    check("pp_no_ovf", 32'(evt_overflow), 32'd0);
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("hold_data", evt_data, 32'd2);
      check("hold_valid", 32'(evt_valid), 32'd1);
    end
    evt_ready = 1'b1;
    check("pp_d0", evt_data, 32'd2); cyc();
    check("pp_d1", evt_data, 32'd3); cyc();
    check("pp_d2", evt_data, 32'd4); cyc();
    check("pp_d3", evt_data, 32'd9); cyc();
    check("pp_empty", 32'(evt_valid), 32'd0);

    // Randomized traffic with one mid-run reset.
    held = sw_in;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) held = held ^ (32'h1 << $urandom_range(0, 31));
      sw_in = ($urandom_range(0, 9) == 0) ? (held ^ $urandom()) : held;
      if ($urandom_range(0, 2) == 0) gpio_out = 32'($urandom_range(0, 3));
      evt_ready = ($urandom_range(0, 2) == 0);
      ovf_clr = ($urandom_range(0, 9) == 0);
      rst = !(i >= 300 && i < 302);
      cyc();
    end
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
